mem_access: RTL and testbench
=============================

// Module: mem_access
// PURPOSE
//  Memory stage of the five-stage pipeline, between the execute stage and writeback.
//  - Consumes the execute->memory bus.
//  - Runs loads and stores against the data RAM over a variable-latency req/ack port.
//  - Aligns and extends load data; flags misaligned addresses.
//  - Forwards the memory->writeback bus.
// PARAMETERS
//  none -- widths are fixed by the execute->memory (163b) and memory->writeback (125b) bus formats
// PORTS
//  clk            in   1    pipeline clock
//  resetn         in   1    asynchronous, active-low reset
//  MEM_valid      in   1    stage holds a valid instruction
//  EXE_MEM_bus_r  in   163  {mem_control[162:155], store_data[154:123], exe_result[122:91], pass[90:0]}
//  WB_allow_in    in   1    writeback accepts this cycle
//  cancel         in   1    exception flush from writeback
//  MEM_over       out  1    stage result complete
//  MEM_WB_bus     out  125  {mem_result[124:93], adel[92], ades[91], pass[90:0]}
//  MEM_wdest      out  5    pass rf_wdest & {5{MEM_valid}} (for hazard check)
//  MEM_pc         out  32   pass pc[31:0]
//  dm_req         out  1    data RAM request
//  dm_wr          out  1    1 = store
//  dm_addr        out  32   word address {addr[31:2],2'b00}
//  dm_wstrb       out  4    byte write strobes
//  dm_wdata       out  32   store data, lane-replicated
//  dm_rdata       in   32   read data, valid with dm_ack
//  dm_ack         in   1    request done, 1 cycle
// BEHAVIOUR
//  Field decode
//  - mem_control: [7] load, [6] store, [5:4] size (00 byte, 01 half, 10 word), [3] load sign-extend, [2:0] reserved 0.
//  - addr = exe_result.
//  Alignment
//  - adel = load & misaligned; ades = store & misaligned.
//  - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
//  FSM states: IDLE, REQ, DONE. Reset -> IDLE.
//  - Reset values: dm_req=0, dm_wr=0, dm_addr=0, dm_wstrb=0, dm_wdata=0, rdata_r=0.
//  - IDLE, MEM_valid & (load|store) & aligned & !cancel:
//    - Register dm_req=1, dm_wr=store, addr, strobes, wdata.
//    - Go to REQ.
//  - IDLE, otherwise:
//    - MEM_over = MEM_valid & !cancel (combinational, 0 extra cycles).
//    - mem_result = exe_result. This covers non-memory ops and misaligned ops, so BadVAddr = addr.
//  - REQ:
//    - Hold dm_req and all dm_* stable until dm_ack.
//    - On dm_ack: drop dm_req, capture aligned load data into rdata_r, go to DONE.
//    - MEM_over = 0.
//  - DONE:
//    - MEM_over = 1; mem_result = load ? rdata_r : exe_result.
//    - Go to IDLE when WB_allow_in.
//  Latency: aligned load/store with ack one cycle after req -> MEM_over 2 cycles after entry.
//  Store strobes and data
//  - byte: wstrb = 4'b0001 << addr[1:0], wdata = {4{sd[7:0]}}.
//  - half: wstrb = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{sd[15:0]}}.
//  - word: wstrb = 4'b1111, wdata = sd.
//  - Loads: wstrb = 0.
//  Load extraction
//  - byte: lane addr[1:0]; half: lane addr[1].
//  - Sign-extend if load_sign, else zero-extend. Word is unchanged.
//  cancel
//  - In IDLE: no request is issued, MEM_over = 0.
//  - In REQ: the request is still held to dm_ack (a req is never retracted); data is discarded; go to IDLE, not DONE.
//  - In DONE: go to IDLE immediately, MEM_over = 0.
//  Reset mid-REQ: FSM -> IDLE and dm_req -> 0 asynchronously; the RAM side is reset with it.
//  Pass-through field [90:0] is driven combinationally from the input bus in every state.
// TESTING
//  - ALU op, MEM_valid=1, mem_control=0, exe_result=0x1234 -> MEM_over=1 same cycle, mem_result=0x1234, dm_req=0.
//  - lb, addr=0x103, rdata=0x80FF_0000, ack 1 cycle after req -> dm_addr=0x100, mem_result=0xFFFF_FF80, MEM_over in cycle 2.
//  - sh, addr=0x202, sd=0xABCD1234, ack after 3 cycles -> dm_wstrb=1100, dm_wdata=0x1234_1234, dm_req held 3 cycles.
//  - lw, addr=0x301 -> no dm_req, adel=1, ades=0, mem_result=0x301, MEM_over=1 same cycle.
//  - lhu, addr=0x402, WB_allow_in=0 for 2 cycles in DONE -> MEM_over and mem_result hold; IDLE the cycle after WB_allow_in=1.
//  - sw in REQ, cancel pulsed before ack -> dm_req held to ack, MEM_over never 1, IDLE after ack; resetn=0 mid-REQ -> dm_req=0 at once.

Source files
------------

// File: rtl/mem_access.sv
// Memory stage of the five-stage pipeline. Takes the execute->memory bus,
// runs loads and stores against the data RAM over a req/ack port, aligns
// and extends load data, flags misaligned accesses and forwards the
// memory->writeback bus.
// The pass-through field carries rf_wdest in [36:32] and pc in [31:0].
module mem_access (
    input  logic         clk,
    input  logic         resetn,
    input  logic         MEM_valid,
    input  logic [162:0] EXE_MEM_bus_r,
    input  logic         WB_allow_in,
    input  logic         cancel,
    output logic         MEM_over,
    output logic [124:0] MEM_WB_bus,
    output logic [4:0]   MEM_wdest,
    output logic [31:0]  MEM_pc,
    output logic         dm_req,
    output logic         dm_wr,
    output logic [31:0]  dm_addr,
    output logic [3:0]   dm_wstrb,
    output logic [31:0]  dm_wdata,
    input  logic [31:0]  dm_rdata,
    input  logic         dm_ack
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    // Execute->memory bus fields
    logic [7:0]  memControl;
    logic [31:0] storeData;
    logic [31:0] exeResult;
    logic [90:0] passBus;
    logic        isLoad;
    logic        isStore;
    logic [1:0]  accessSize;
    logic        loadSign;
    logic        unusedReservedBits;

    assign memControl         = EXE_MEM_bus_r[162:155];
    assign storeData          = EXE_MEM_bus_r[154:123];
    assign exeResult          = EXE_MEM_bus_r[122:91];
    assign passBus            = EXE_MEM_bus_r[90:0];
    assign isLoad             = memControl[7];
    assign isStore            = memControl[6];
    assign accessSize         = memControl[5:4];
    assign loadSign           = memControl[3];
    assign unusedReservedBits = ^memControl[2:0];

    // Alignment check; a misaligned op never reaches the RAM and its
    // exe_result doubles as BadVAddr on the writeback bus.
    logic misaligned;
    logic adel;
    logic ades;
    logic startReq;

    assign misaligned = ((accessSize == 2'b01) && exeResult[0]) ||
                        ((accessSize == 2'b10) && (exeResult[1:0] != 2'b00));
    assign adel       = isLoad & misaligned;
    assign ades       = isStore & misaligned;
    assign startReq   = MEM_valid & (isLoad | isStore) & ~misaligned & ~cancel;

    // Registered state and RAM-side outputs
    state_t      state_q;
    logic        dmReq_q;
    logic        dmWr_q;
    logic [31:0] dmAddr_q;
    logic [3:0]  dmWstrb_q;
    logic [31:0] dmWdata_q;
    logic [31:0] rdata_q;
    logic [1:0]  ldLane_q;
    logic [1:0]  ldSize_q;
    logic        ldSign_q;
    logic        ldIsLoad_q;
    logic        cancelled_q;

    // Next values for the store strobes/data and the aligned load word
    logic [3:0]  wstrb_d;
    logic [31:0] wdata_d;
    logic [31:0] loadData_d;

    // Store lane strobes and lane-replicated write data for the current op
    always_comb begin
        wstrb_d = 4'b0000;
        wdata_d = storeData;
        case (accessSize)
            2'b00: begin
                wstrb_d = 4'b0001 << exeResult[1:0];
                wdata_d = {4{storeData[7:0]}};
            end
            2'b01: begin
                wstrb_d = exeResult[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{storeData[15:0]}};
            end
            default: begin
                wstrb_d = 4'b1111;
                wdata_d = storeData;
            end
        endcase
        if (!isStore) begin
            wstrb_d = 4'b0000;
        end
    end

    // Pick the addressed lane out of the returned word and extend it,
    // using the access shape latched when the request went out
    always_comb begin
        logic [7:0]  byteLane;
        logic [15:0] halfLane;
        byteLane = dm_rdata[7:0];
        case (ldLane_q)
            2'd0:    byteLane = dm_rdata[7:0];
            2'd1:    byteLane = dm_rdata[15:8];
            2'd2:    byteLane = dm_rdata[23:16];
            default: byteLane = dm_rdata[31:24];
        endcase
        halfLane = ldLane_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        case (ldSize_q)
            2'b00:   loadData_d = ldSign_q ? {{24{byteLane[7]}}, byteLane} : {24'd0, byteLane};
            2'b01:   loadData_d = ldSign_q ? {{16{halfLane[15]}}, halfLane} : {16'd0, halfLane};
            default: loadData_d = dm_rdata;
        endcase
    end

    // Request FSM: issue once, hold the request until ack, then present the result
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            dmReq_q     <= 1'b0;
            dmWr_q      <= 1'b0;
            dmAddr_q    <= 32'd0;
            dmWstrb_q   <= 4'd0;
            dmWdata_q   <= 32'd0;
            rdata_q     <= 32'd0;
            ldLane_q    <= 2'd0;
            ldSize_q    <= 2'd0;
            ldSign_q    <= 1'b0;
            ldIsLoad_q  <= 1'b0;
            cancelled_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (startReq) begin
                        dmReq_q     <= 1'b1;
                        dmWr_q      <= isStore;
                        dmAddr_q    <= {exeResult[31:2], 2'b00};
                        dmWstrb_q   <= wstrb_d;
                        dmWdata_q   <= wdata_d;
                        ldLane_q    <= exeResult[1:0];
                        ldSize_q    <= accessSize;
                        ldSign_q    <= loadSign;
                        ldIsLoad_q  <= isLoad;
                        cancelled_q <= 1'b0;
                        state_q     <= REQ;
                    end
                end
                REQ: begin
                    if (cancel) begin
                        cancelled_q <= 1'b1;
                    end
                    if (dm_ack) begin
                        dmReq_q <= 1'b0;
                        rdata_q <= loadData_d;
                        state_q <= (cancel || cancelled_q) ? IDLE : DONE;
                    end
                end
                DONE: begin
                    if (cancel || WB_allow_in) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Completion flag and result select for the writeback bus
    logic        memOver;
    logic [31:0] memResult;

    always_comb begin
        memOver   = 1'b0;
        memResult = exeResult;
        case (state_q)
            IDLE: memOver = MEM_valid & ~cancel & ~startReq;
            REQ:  memOver = 1'b0;
            DONE: begin
                memOver   = ~cancel;
                memResult = ldIsLoad_q ? rdata_q : exeResult;
            end
            default: memOver = 1'b0;
        endcase
    end

    assign MEM_over   = memOver;
    assign MEM_WB_bus = {memResult, adel, ades, passBus};
    assign MEM_wdest  = passBus[36:32] & {5{MEM_valid}};
    assign MEM_pc     = passBus[31:0];

    assign dm_req   = dmReq_q;
    assign dm_wr    = dmWr_q;
    assign dm_addr  = dmAddr_q;
    assign dm_wstrb = dmWstrb_q;
    assign dm_wdata = dmWdata_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for the memory stage: a scripted RAM responder with adjustable ack
// delay, and a scoreboard of expected writeback results and RAM requests.
module tb_mem_access;

    logic         clk = 1'b0;
    logic         resetn;
    logic         MEM_valid;
    logic [162:0] EXE_MEM_bus_r;
    logic         WB_allow_in;
    logic         cancel;
    logic         MEM_over;
    logic [124:0] MEM_WB_bus;
    logic [4:0]   MEM_wdest;
    logic [31:0]  MEM_pc;
    logic         dm_req;
    logic         dm_wr;
    logic [31:0]  dm_addr;
    logic [3:0]   dm_wstrb;
    logic [31:0]  dm_wdata;
    logic [31:0]  dm_rdata;
    logic         dm_ack;

    always #5 clk = ~clk;

    mem_access dut (
        .clk           (clk),
        .resetn        (resetn),
        .MEM_valid     (MEM_valid),
        .EXE_MEM_bus_r (EXE_MEM_bus_r),
        .WB_allow_in   (WB_allow_in),
        .cancel        (cancel),
        .MEM_over      (MEM_over),
        .MEM_WB_bus    (MEM_WB_bus),
        .MEM_wdest     (MEM_wdest),
        .MEM_pc        (MEM_pc),
        .dm_req        (dm_req),
        .dm_wr         (dm_wr),
        .dm_addr       (dm_addr),
        .dm_wstrb      (dm_wstrb),
        .dm_wdata      (dm_wdata),
        .dm_rdata      (dm_rdata),
        .dm_ack        (dm_ack)
    );

    typedef struct {
        logic [31:0] memResult;
        logic        adel;
        logic        ades;
        logic [90:0] passBits;
        logic [4:0]  wdest;
        logic [31:0] pc;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        int          reqCycles;
        int          latency;
    } expect_t;

    expect_t     expQ[$];
    int          compareCount = 0;
    int          errorCount   = 0;
    int          ackDelay     = 1;
    logic [31:0] ramWord      = 32'd0;
    int          reqAge       = 0;

    // Counts one comparison and reports it when observed and expected differ
    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        compareCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference load alignment and extension
    function automatic logic [31:0] modelLoad(input logic [7:0] ctrl, input logic [31:0] addr, input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        case (addr[1:0])
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = addr[1] ? rdata[31:16] : rdata[15:0];
        if (ctrl[5:4] == 2'b00)      return ctrl[3] ? {{24{b[7]}}, b} : {24'd0, b};
        else if (ctrl[5:4] == 2'b01) return ctrl[3] ? {{16{h[15]}}, h} : {16'd0, h};
        else                         return rdata;
    endfunction

    // RAM responder: ack once the request has been up for ackDelay cycles
    initial begin
        dm_ack   = 1'b0;
        dm_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            dm_ack = 1'b0;
            if (resetn && dm_req) begin
                reqAge++;
                if (reqAge >= ackDelay) begin
                    dm_ack   = 1'b1;
                    dm_rdata = ramWord;
                    reqAge   = 0;
                end
            end else begin
                reqAge = 0;
            end
        end
    end

    // Drives one instruction into the stage and queues what it should produce
    task automatic applyStimulus(input logic [7:0] ctrl, input logic [31:0] sd, input logic [31:0] addr,
                                 input logic [4:0] wdest, input logic [31:0] pc,
                                 input logic [31:0] rdata, input int delay);
        expect_t     e;
        logic [90:0] p;
        logic        mis;
        logic        goesOut;
        p        = {$urandom(), $urandom(), $urandom()};
        p[36:32] = wdest;
        p[31:0]  = pc;
        mis = ((ctrl[5:4] == 2'b01) && addr[0]) || ((ctrl[5:4] == 2'b10) && (addr[1:0] != 2'b00));
        goesOut     = (ctrl[7] | ctrl[6]) & ~mis;
        e.adel      = ctrl[7] & mis;
        e.ades      = ctrl[6] & mis;
        e.memResult = (goesOut && ctrl[7]) ? modelLoad(ctrl, addr, rdata) : addr;
        e.passBits  = p;
        e.wdest     = wdest;
        e.pc        = pc;
        e.wr        = ctrl[6];
        e.addr      = {addr[31:2], 2'b00};
        e.wstrb     = 4'b0000;
        e.wdata     = sd;
        if (ctrl[6]) begin
            case (ctrl[5:4])
                2'b00: begin
                    case (addr[1:0])
                        2'd0:    e.wstrb = 4'b0001;
                        2'd1:    e.wstrb = 4'b0010;
                        2'd2:    e.wstrb = 4'b0100;
                        default: e.wstrb = 4'b1000;
                    endcase
                    e.wdata = {sd[7:0], sd[7:0], sd[7:0], sd[7:0]};
                end
                2'b01: begin
                    e.wstrb = addr[1] ? 4'b1100 : 4'b0011;
                    e.wdata = {sd[15:0], sd[15:0]};
                end
                default: e.wstrb = 4'b1111;
            endcase
        end
        e.reqCycles = goesOut ? delay : 0;
        e.latency   = goesOut ? delay + 1 : 0;
        ramWord       = rdata;
        ackDelay      = delay;
        EXE_MEM_bus_r = {ctrl, sd, addr, p};
        MEM_valid     = 1'b1;
        expQ.push_back(e);
    endtask

    // Waits for MEM_over, checks RAM traffic on the way, then pops and compares
    task automatic collectResult(input string tag, input int holdCycles);
        expect_t e;
        int      cyc;
        int      reqSeen;
        bit      seen;
        cyc     = 0;
        reqSeen = 0;
        seen    = 1'b0;
        while (!seen && cyc <= 40) begin
            @(negedge clk);
            if (dm_req) begin
                reqSeen++;
                checkOutput({tag, "_dm_addr"}, dm_addr, expQ[0].addr);
                checkOutput({tag, "_dm_wr"}, dm_wr, expQ[0].wr);
                checkOutput({tag, "_dm_wstrb"}, dm_wstrb, expQ[0].wstrb);
                if (expQ[0].wr) checkOutput({tag, "_dm_wdata"}, dm_wdata, expQ[0].wdata);
            end
            if (MEM_over) seen = 1'b1;
            else          cyc++;
        end
        e = expQ.pop_front();
        checkOutput({tag, "_completed"}, seen, 1'b1);
        if (seen) begin
            checkOutput({tag, "_latency"}, cyc, e.latency);
            checkOutput({tag, "_req_cycles"}, reqSeen, e.reqCycles);
            checkOutput({tag, "_result"}, MEM_WB_bus[124:93], e.memResult);
            checkOutput({tag, "_adel"}, MEM_WB_bus[92], e.adel);
            checkOutput({tag, "_ades"}, MEM_WB_bus[91], e.ades);
            checkOutput({tag, "_pass"}, MEM_WB_bus[90:0], e.passBits);
            checkOutput({tag, "_wdest"}, MEM_wdest, e.wdest);
            checkOutput({tag, "_pc"}, MEM_pc, e.pc);
            for (int h = 0; h < holdCycles; h++) begin
                @(posedge clk);
                #1;
                if (h == holdCycles - 1) WB_allow_in = 1'b1;
                @(negedge clk);
                checkOutput({tag, "_hold_over"}, MEM_over, 1'b1);
                checkOutput({tag, "_hold_result"}, MEM_WB_bus[124:93], e.memResult);
            end
        end
        WB_allow_in = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          reqCnt;
        bit          overSeen;
        logic [90:0] p;
        resetn        = 1'b0;
        MEM_valid     = 1'b0;
        EXE_MEM_bus_r = '0;
        WB_allow_in   = 1'b1;
        cancel        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_dm_req", dm_req, 1'b0);
        checkOutput("rst_dm_wr", dm_wr, 1'b0);
        checkOutput("rst_dm_addr", dm_addr, 32'd0);
        checkOutput("rst_dm_wstrb", dm_wstrb, 4'd0);
        checkOutput("rst_dm_wdata", dm_wdata, 32'd0);
        checkOutput("rst_over", MEM_over, 1'b0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(8'h00, 32'h0,        32'h0000_1234, 5'd3,  32'hBFC0_0000, 32'h0,        1); collectResult("alu", 0);
        applyStimulus(8'h88, 32'h0,        32'h0000_0103, 5'd4,  32'hBFC0_0004, 32'h80FF_0000, 1); collectResult("lb", 0);
        applyStimulus(8'h50, 32'hABCD_1234, 32'h0000_0202, 5'd0,  32'hBFC0_0008, 32'h0,        3); collectResult("sh", 0);
        applyStimulus(8'hA0, 32'h0,        32'h0000_0301, 5'd5,  32'hBFC0_000C, 32'h1111_1111, 1); collectResult("lw_mis", 0);
        WB_allow_in = 1'b0;
        applyStimulus(8'h90, 32'h0,        32'h0000_0402, 5'd6,  32'hBFC0_0010, 32'hBEEF_1234, 1); collectResult("lhu_hold", 2);
        applyStimulus(8'h00, 32'h0,        32'h0000_5678, 5'd7,  32'hBFC0_0014, 32'h0,        1); collectResult("alu_after", 0);
        applyStimulus(8'h98, 32'h0,        32'h0000_0800, 5'd8,  32'hBFC0_0018, 32'h1234_8001, 2); collectResult("lh", 0);
        applyStimulus(8'h80, 32'h0,        32'h0000_0901, 5'd9,  32'hBFC0_001C, 32'h0000_9A00, 1); collectResult("lbu", 0);
        applyStimulus(8'h40, 32'h0000_0055, 32'h0000_0A03, 5'd0,  32'hBFC0_0020, 32'h0,        2); collectResult("sb", 0);
        applyStimulus(8'h60, 32'hDEAD_BEEF, 32'h0000_0B00, 5'd0,  32'hBFC0_0024, 32'h0,        1); collectResult("sw", 0);
        applyStimulus(8'h50, 32'h0000_7777, 32'h0000_0C01, 5'd0,  32'hBFC0_0028, 32'h0,        1); collectResult("sh_mis", 0);
        applyStimulus(8'hA0, 32'h0,        32'h0000_0D04, 5'd31, 32'hBFC0_002C, 32'hCAFE_F00D, 1); collectResult("lw", 0);

        // cancel during REQ: request held to ack, no completion, back to IDLE
        p             = '0;
        EXE_MEM_bus_r = {8'h60, 32'h1111_2222, 32'h0000_0500, p};
        MEM_valid     = 1'b1;
        ackDelay      = 3;
        @(negedge clk);
        checkOutput("cxl_entry_over", MEM_over, 1'b0);
        @(posedge clk);
        #1;
        cancel    = 1'b1;
        MEM_valid = 1'b0;
        reqCnt    = 0;
        overSeen  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (dm_req) reqCnt++;
            if (MEM_over) overSeen = 1'b1;
            @(posedge clk);
            #1;
            cancel = 1'b0;
        end
        checkOutput("cxl_req_cycles", reqCnt, 3);
        checkOutput("cxl_never_over", overSeen, 1'b0);
        checkOutput("cxl_idle_req", dm_req, 1'b0);

        // cancel in IDLE: no request, no completion
        EXE_MEM_bus_r = {8'hA0, 32'h0, 32'h0000_0700, p};
        MEM_valid     = 1'b1;
        cancel        = 1'b1;
        @(negedge clk);
        checkOutput("cxl_idle_over", MEM_over, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("cxl_idle_noreq", dm_req, 1'b0);
        cancel    = 1'b0;
        MEM_valid = 1'b0;
        @(posedge clk);
        #1;

        // reset while a request is outstanding
        EXE_MEM_bus_r = {8'h60, 32'h0000_0077, 32'h0000_0600, p};
        MEM_valid     = 1'b1;
        ackDelay      = 6;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checkOutput("rstmid_req_up", dm_req, 1'b1);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("rstmid_req", dm_req, 1'b0);
        checkOutput("rstmid_wstrb", dm_wstrb, 4'd0);
        checkOutput("rstmid_addr", dm_addr, 32'd0);
        MEM_valid = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(8'h00, 32'h0, 32'h0000_9999, 5'd12, 32'hBFC0_0030, 32'h0, 1); collectResult("alu_post_rst", 0);
        MEM_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, errorCount);
        $finish;
    end

endmodule
